// File: rtl/aes_pkg.sv
// Shared AES-128 constants, the S-box, the core state type and GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned KS_W       = 1408;

    typedef logic [0:127] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } aes_core_state_e;

    // Entry 0 is the leftmost byte of the concatenation.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return gf_mul2(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when final),
// AddRoundKey. State bytes are column-major, byte i at [i*8 +:8].
module aes_round
    import aes_pkg::*;
(
    input  aes_block_t           blk_i,
    input  logic [0:BLOCK_W-1]   rkey_i,
    input  logic                 is_final_i,
    output aes_block_t           blk_o
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[blk_i[i*8 +: 8]];
        end
        // Row r of column c takes the byte from column (c + r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c + 0] = gf_mul2(sr[4*c]) ^ gf_mul3(sr[4*c + 1]) ^ sr[4*c + 2] ^ sr[4*c + 3];
            mc[4*c + 1] = sr[4*c] ^ gf_mul2(sr[4*c + 1]) ^ gf_mul3(sr[4*c + 2]) ^ sr[4*c + 3];
            mc[4*c + 2] = sr[4*c] ^ sr[4*c + 1] ^ gf_mul2(sr[4*c + 2]) ^ gf_mul3(sr[4*c + 3]);
            mc[4*c + 3] = gf_mul3(sr[4*c]) ^ sr[4*c + 1] ^ sr[4*c + 2] ^ gf_mul2(sr[4*c + 3]);
        end
    end

    always_comb begin
        blk_o = '0;
        for (int i = 0; i < 16; i++) begin
            blk_o[i*8 +: 8] = (is_final_i ? sr[i] : mc[i]) ^ rkey_i[i*8 +: 8];
        end
    end

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encrypt core, ROUNDS_PER_CYCLE chained rounds per clock.
// Define AES_KEY_LATCH_EN to capture key_schedule at accept instead of reading it live.
module aes_encrypt_core
    import aes_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 2,
    parameter int unsigned TAG_W            = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:BLOCK_W-1] in_block,
    input  logic [0:KS_W-1]    key_schedule,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:BLOCK_W-1] out_block,
    output logic [TAG_W-1:0]   out_tag
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
        $error("aes_encrypt_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    localparam logic [3:0] RndStep = 4'(ROUNDS_PER_CYCLE);
    localparam logic [3:0] RndLast = 4'(NUM_ROUNDS + 1 - ROUNDS_PER_CYCLE);

    aes_core_state_e   state_q, state_d;
    logic [3:0]        rnd_q, rnd_d;
    aes_block_t        blk_q, blk_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    aes_block_t        out_block_q, out_block_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [0:KS_W-1]   key_use;
    logic              rnd_legal;

`ifdef AES_KEY_LATCH_EN
    logic [0:KS_W-1] key_q, key_d;

    always_comb begin
        key_d = key_q;
        if (state_q == IDLE && in_valid) begin
            key_d = key_schedule;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    assign key_use = key_q;
`else
    assign key_use = key_schedule;

`ifndef SYNTHESIS
    // Caller contract: the live key must not move while a block is in flight.
    logic [0:KS_W-1] key_prev_q;

    always_ff @(posedge clk) begin
        key_prev_q <= key_schedule;
        if (!rst && state_q != IDLE) begin
            assert (key_schedule == key_prev_q)
            else $error("aes_encrypt_core: key_schedule changed while busy");
        end
    end
`endif
`endif

    aes_block_t chain [ROUNDS_PER_CYCLE+1];
    assign chain[0] = blk_q;

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [4:0] ridx;
        logic [3:0] kidx;
        assign ridx = {1'b0, rnd_q} + 5'(j);
        assign kidx = (ridx > 5'(NUM_ROUNDS)) ? 4'(NUM_ROUNDS) : ridx[3:0];

        aes_round u_round (
            .blk_i      (chain[j]),
            .rkey_i     (key_use[int'(kidx)*BLOCK_W +: BLOCK_W]),
            .is_final_i (ridx == 5'(NUM_ROUNDS)),
            .blk_o      (chain[j+1])
        );
    end

    // Legal RUN values are 1, 1+R, ..., 11-R.
    assign rnd_legal = (rnd_q >= 4'd1) && (rnd_q <= RndLast) &&
                       (((rnd_q - 4'd1) % RndStep) == 4'd0);

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        blk_d       = blk_q;
        tag_d       = tag_q;
        out_block_d = out_block_q;
        out_tag_d   = out_tag_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = in_block ^ key_schedule[0:BLOCK_W-1];
                    tag_d   = in_tag;
                    rnd_d   = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!rnd_legal) begin
                    state_d = IDLE;
                    rnd_d   = '0;
                end else begin
                    blk_d = chain[ROUNDS_PER_CYCLE];
                    rnd_d = rnd_q + RndStep;
                    if (rnd_q == RndLast) begin
                        out_block_d = chain[ROUNDS_PER_CYCLE];
                        out_tag_d   = tag_q;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    rnd_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                rnd_d   = '0;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            blk_q       <= '0;
            tag_q       <= '0;
            out_block_q <= '0;
            out_tag_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            blk_q       <= blk_d;
            tag_q       <= tag_d;
            out_block_q <= out_block_d;
            out_tag_q   <= out_tag_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Bench for aes_encrypt_core: four instances (1, 2, 5, 10 rounds per clock) against a
// byte-level AES model; index 1 (two rounds per clock) also covers the handshake cases.
module tb_aes_encrypt_core;

    logic              clk;
    logic              rst;
    logic [3:0]        in_valid_v;
    logic [3:0]        out_ready_v;
    logic [0:127]      in_block;
    logic [0:1407]     key_schedule;
    logic [7:0]        in_tag;
    logic              in_ready_v  [4];
    logic              out_valid_v [4];
    logic [0:127]      out_block_a [4];
    logic [7:0]        out_tag_a   [4];

    int errors = 0;
    int checks = 0;
    logic [7:0] sbox_m [256];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int RPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
        aes_encrypt_core #(
            .ROUNDS_PER_CYCLE (RPC),
            .TAG_W            (8)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid_v[g]),
            .in_ready     (in_ready_v[g]),
            .in_block     (in_block),
            .key_schedule (key_schedule),
            .in_tag       (in_tag),
            .out_valid    (out_valid_v[g]),
            .out_ready    (out_ready_v[g]),
            .out_block    (out_block_a[g]),
            .out_tag      (out_tag_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rpc(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        logic hi;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
        end
    endtask

    function automatic logic [0:1407] expand_key(input logic [0:127] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [0:1407] ks;
        for (int i = 0; i < 4; i++) w[i] = key[i*32 +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[i*32 +: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [0:127] ref_encrypt(input logic [0:127] pt,
                                                 input logic [0:1407] ks);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [0:127] ct;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int i = 0; i < 16; i++) s[i] = pt[i*8 +: 8] ^ ks[i*8 +: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++)
                            acc = acc ^ gmul(coef[(k - r + 4) % 4], s[k + 4*c]);
                        t[r + 4*c] = acc;
                    end
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[rnd*128 + i*8 +: 8];
        end
        for (int i = 0; i < 16; i++) ct[i*8 +: 8] = s[i];
        return ct;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one block on every instance in mask; record first out_valid per instance.
    task automatic run_all(input logic [3:0] mask, input logic [0:127] pt,
                           input logic [0:1407] ks, input logic [7:0] tag,
                           input logic [0:127] exp, input string name, input bit scramble);
        int         lat [4];
        logic [0:127] blk [4];
        logic [7:0] tg  [4];
        for (int g = 0; g < 4; g++) begin
            lat[g] = 0; blk[g] = '0; tg[g] = '0;
        end
        key_schedule = ks;
        in_block     = pt;
        in_tag       = tag;
        in_valid_v   = mask;
        tick();
        in_valid_v = '0;
        if (scramble) begin
            for (int i = 0; i < 44; i++) key_schedule[i*32 +: 32] = $urandom;
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            for (int g = 0; g < 4; g++) begin
                if (mask[g] && lat[g] == 0 && out_valid_v[g]) begin
                    lat[g] = k;
                    blk[g] = out_block_a[g];
                    tg[g]  = out_tag_a[g];
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            if (mask[g]) begin
                chk($sformatf("%s_lat_r%0d", name, rpc(g)), 128'(lat[g]), 128'(10 / rpc(g)));
                chk($sformatf("%s_blk_r%0d", name, rpc(g)), blk[g], exp);
                chk($sformatf("%s_tag_r%0d", name, rpc(g)), 128'(tg[g]), 128'(tag));
            end
        end
    endtask

    initial begin
        logic [0:1407] ks;
        logic [0:127]  pt;
        logic [0:127]  exp;
        logic [0:127]  b2b_pt [4];
        logic [0:127]  rx_blk [4];
        logic [7:0]    rx_tag [4];
        int            rx_t   [4];
        int            acc_t  [4];
        int            nsent;
        int            nrecv;
        bit            acc;
        bit            flag;

        build_sbox();
        rst          = 1'b1;
        in_valid_v   = '0;
        out_ready_v  = 4'hF;
        in_block     = '0;
        key_schedule = '0;
        in_tag       = '0;
        repeat (3) tick();
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rst_in_ready_r%0d", rpc(g)), 128'(in_ready_v[g]), 128'd1);
            chk($sformatf("rst_out_valid_r%0d", rpc(g)), 128'(out_valid_v[g]), 128'd0);
            chk($sformatf("rst_out_block_r%0d", rpc(g)), out_block_a[g], 128'd0);
            chk($sformatf("rst_out_tag_r%0d", rpc(g)), 128'(out_tag_a[g]), 128'd0);
        end
        rst = 1'b0;
        tick();

        // Known-answer vectors on all four widths.
        ks = expand_key(128'h000102030405060708090a0b0c0d0e0f);
        run_all(4'hF, 128'h00112233445566778899aabbccddeeff, ks, 8'h5a,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips_c1", 1'b0);
        ks = expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_all(4'hF, 128'h3243f6a8885a308d313198a2e0370734, ks, 8'ha5,
                128'h3925841d02dc09fbdc118597196a0b32, "fips_b", 1'b0);

        for (int i = 0; i < 6; i++) begin
            ks = expand_key(rand128());
            pt = rand128();
            run_all(4'hF, pt, ks, 8'($urandom), ref_encrypt(pt, ks), $sformatf("rnd%0d", i), 1'b0);
        end

        // Backpressure on the two-rounds-per-clock instance.
        ks  = expand_key(rand128());
        pt  = rand128();
        exp = ref_encrypt(pt, ks);
        key_schedule = ks;
        in_block     = pt;
        in_tag       = 8'h33;
        out_ready_v  = 4'b1101;
        in_valid_v   = 4'b0010;
        tick();
        in_valid_v = '0;
        repeat (4) tick();
        chk("bp_early_valid", 128'(out_valid_v[1]), 128'd0);
        tick();
        chk("bp_valid", 128'(out_valid_v[1]), 128'd1);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("bp_blk%0d", i), out_block_a[1], exp);
            chk($sformatf("bp_tag%0d", i), 128'(out_tag_a[1]), 128'h33);
            chk($sformatf("bp_in_ready%0d", i), 128'(in_ready_v[1]), 128'd0);
            chk($sformatf("bp_out_valid%0d", i), 128'(out_valid_v[1]), 128'd1);
            in_valid_v[1] = ~in_valid_v[1];
            in_block      = rand128();
            tick();
        end
        in_valid_v  = '0;
        chk("bp_blk_final", out_block_a[1], exp);
        out_ready_v = 4'hF;
        tick();
        chk("bp_rel_valid", 128'(out_valid_v[1]), 128'd0);
        chk("bp_rel_ready", 128'(in_ready_v[1]), 128'd1);
        flag = 1'b1;
        repeat (4) begin
            tick();
            if (out_valid_v[1] || !in_ready_v[1]) flag = 1'b0;
        end
        chk("bp_pulses_ignored", 128'(flag), 128'd1);

        // Back-to-back: four blocks with in_valid held high.
        ks = expand_key(rand128());
        key_schedule = ks;
        for (int i = 0; i < 4; i++) b2b_pt[i] = rand128();
        nsent = 0;
        nrecv = 0;
        for (int i = 0; i < 4; i++) begin
            rx_t[i] = 0; acc_t[i] = 0; rx_blk[i] = '0; rx_tag[i] = '0;
        end
        in_block   = b2b_pt[0];
        in_tag     = 8'h01;
        in_valid_v = 4'b0010;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc = in_valid_v[1] && in_ready_v[1];
            tick();
            if (acc) begin
                acc_t[nsent] = cyc;
                nsent++;
                if (nsent < 4) begin
                    in_block = b2b_pt[nsent];
                    in_tag   = 8'(nsent + 1);
                end else begin
                    in_valid_v = '0;
                end
            end
            if (out_valid_v[1] && nrecv < 4) begin
                rx_blk[nrecv] = out_block_a[1];
                rx_tag[nrecv] = out_tag_a[1];
                rx_t[nrecv]   = cyc;
                nrecv++;
            end
        end
        in_valid_v = '0;
        chk("b2b_count", 128'(nrecv), 128'd4);
        chk("b2b_first_latency", 128'(rx_t[0] - acc_t[0]), 128'd5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_blk%0d", i), rx_blk[i], ref_encrypt(b2b_pt[i], ks));
            chk($sformatf("b2b_tag%0d", i), 128'(rx_tag[i]), 128'(i + 1));
            if (i > 0) chk($sformatf("b2b_gap%0d", i), 128'(rx_t[i] - rx_t[i-1]), 128'd7);
        end

        // Reset during the second RUN cycle drops the block.
        ks = expand_key(rand128());
        key_schedule = ks;
        in_block     = rand128();
        in_tag       = 8'h77;
        in_valid_v   = 4'b0010;
        tick();
        in_valid_v = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_out_valid", 128'(out_valid_v[1]), 128'd0);
        chk("rr_in_ready", 128'(in_ready_v[1]), 128'd1);
        flag = 1'b0;
        repeat (8) begin
            tick();
            if (out_valid_v[1]) flag = 1'b1;
        end
        chk("rr_no_emit", 128'(flag), 128'd0);
        pt = rand128();
        run_all(4'b0010, pt, ks, 8'h78, ref_encrypt(pt, ks), "rr_next", 1'b0);

`ifdef AES_KEY_LATCH_EN
        ks = expand_key(rand128());
        pt = rand128();
        run_all(4'hF, pt, ks, 8'hc3, ref_encrypt(pt, ks), "key_latch", 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
